mux_test_seq: RTL and testbench

MUX_TEST_SEQ -- requirements
Module: mux_test_seq

---
 rtl/mux_test_seq.sv | 179 +++++++++++++++++
 tb/tb_mux_test_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_test_seq.sv
// mux_test_seq -- built-in self-test sequencer for the selector datapath
//   z = (a & ~b) | (b & c)
// Sweeps all eight {a,b,c} combinations, waits SETTLE cycles after each one,
// then compares the returned z_in against the expected selector output
// (b ? c : a) and counts mismatches.
//
// Parameters:
//   SETTLE      wait cycles between applying a vector and sampling z_in (1..15)
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   start       begins an 8-vector sweep (accepted only in IDLE)
//   abort       terminates a sweep in progress (wins over start in IDLE)
//   z_in        datapath output under test
//   a_out/b_out/c_out  registered stimulus to the datapath
//   busy        high while a sweep is running (APPLY/WAIT/CHECK)
//   done        one-cycle pulse at sweep completion
//   pass        last completed sweep had zero mismatches
//   err_cnt     mismatch count of current or last sweep (saturates at 8)
//   vec_idx     index of the vector currently applied
//
// Optional feature (macro MUX_TEST_FIRST_FAIL_EN):
//   fail_vec    index of the first mismatching vector of the sweep
//   fail_valid  fail_vec holds a captured index

module mux_test_seq #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       z_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
`ifdef MUX_TEST_FIRST_FAIL_EN
    output logic [2:0] fail_vec,
    output logic       fail_valid,
`endif
    output logic [2:0] vec_idx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t     state;
    logic [3:0] settle_cnt;
    logic       expected;
    logic       mismatch;

    always_comb begin
        expected = b_out ? c_out : a_out;
        mismatch = (z_in != expected);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            c_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            vec_idx    <= '0;
`ifdef MUX_TEST_FIRST_FAIL_EN
            fail_vec   <= '0;
            fail_valid <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state   <= ST_APPLY;
                        busy    <= 1'b1;
                        vec_idx <= '0;
                        err_cnt <= '0;
                        pass    <= 1'b0;
`ifdef MUX_TEST_FIRST_FAIL_EN
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
`endif
                    end
                end

                ST_APPLY: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                        c_out <= 1'b0;
                    end else begin
                        {a_out, b_out, c_out} <= vec_idx;
                        settle_cnt <= 4'(SETTLE - 1);
                        state      <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                        c_out <= 1'b0;
                    end else if (settle_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                ST_CHECK: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                        c_out <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            if (err_cnt != 4'd8)
                                err_cnt <= err_cnt + 4'd1;
`ifdef MUX_TEST_FIRST_FAIL_EN
                            if (!fail_valid) begin
                                fail_vec   <= vec_idx;
                                fail_valid <= 1'b1;
                            end
`endif
                        end
                        if (vec_idx == 3'd7) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec_idx <= vec_idx + 3'd1;
                            state   <= ST_APPLY;
                        end
                    end
                end

                ST_DONE: begin
                    // err_cnt is final here, so pass is resolved one cycle after done.
                    done  <= 1'b0;
                    pass  <= (err_cnt == '0);
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    c_out <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_test_seq.sv
// tb_mux_test_seq -- directed self-checking bench for mux_test_seq (SETTLE=2).
// z_in is produced by a golden selector model, tied low, or the inverted
// golden model, selected by `mode`.

module tb_mux_test_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       z_in;
    logic       a_out, b_out, c_out;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [2:0] vec_idx;
`ifdef MUX_TEST_FIRST_FAIL_EN
    logic [2:0] fail_vec;
    logic       fail_valid;
`endif

    int  mode = 0;   // 0 golden, 1 tied low, 2 inverted golden
    int  n_vec = 0;
    int  n_err = 0;

    logic       golden;
    logic [2:0] abc;

    assign abc    = {a_out, b_out, c_out};
    assign golden = (a_out & ~b_out) | (b_out & c_out);
    assign z_in   = (mode == 0) ? golden : (mode == 1) ? 1'b0 : ~golden;

    always #5 clk = ~clk;

    mux_test_seq #(.SETTLE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .z_in       (z_in),
        .a_out      (a_out),
        .b_out      (b_out),
        .c_out      (c_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
`ifdef MUX_TEST_FIRST_FAIL_EN
        .fail_vec   (fail_vec),
        .fail_valid (fail_valid),
`endif
        .vec_idx    (vec_idx)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_abc"}, abc, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_vidx"}, vec_idx, 0);
`ifdef MUX_TEST_FIRST_FAIL_EN
        check({tag, "_fvalid"}, fail_valid, 0);
        check({tag, "_fvec"}, fail_vec, 0);
`endif
    endtask

    // Pulse start for one edge; returns just after the edge that sampled it.
    task automatic pulse_start(input int m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_vidx(input logic [2:0] v);
        int n = 0;
        while (vec_idx !== v && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_vidx", vec_idx, v);
    endtask

    task automatic run_sweep(input int m, input bit chk_stim, input bit extra_start,
                             input int exp_err, input bit exp_pass, input logic [2:0] exp_fvec);
        int lat = 0;
        pulse_start(m);
        check("busy_rise", busy, 1);
        check("err_clr", err_cnt, 0);
        check("pass_clr", pass, 0);
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (extra_start && lat == 10) start = 1'b1;
            if (extra_start && lat == 11) start = 1'b0;
            if (chk_stim && (lat % 4) == 1) begin
                check("stim_abc", abc, 32'(lat / 4));
                check("stim_vidx", vec_idx, 32'(lat / 4));
            end
            if (done) break;
        end
        check("done_lat", lat, 32);
        check("busy_at_done", busy, 0);
        check("err_final", err_cnt, exp_err);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("pass", pass, exp_pass);
        check("abc_idle", abc, 0);
`ifdef MUX_TEST_FIRST_FAIL_EN
        check("fail_valid", fail_valid, (exp_err != 0));
        if (exp_err != 0) check("fail_vec", fail_vec, exp_fvec);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("pass_hold", pass, exp_pass);
        check("err_hold", err_cnt, exp_err);
    endtask

    initial begin
        int done_seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_all_zero("rst");

        // Full sweeps with each z_in source
        run_sweep(0, 1'b1, 1'b0, 0, 1'b1, 3'd0);
        run_sweep(1, 1'b0, 1'b0, 4, 1'b0, 3'd3);
        run_sweep(2, 1'b0, 1'b0, 8, 1'b0, 3'd0);

        // Abort at vec_idx 4 with z_in low: one mismatch (vector 3) counted
        run_sweep(0, 1'b0, 1'b0, 0, 1'b1, 3'd0);
        pulse_start(1);
        wait_vidx(3'd4);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_abc", abc, 0);
        check("abort_done", done, 0);
        check("abort_err", err_cnt, 1);
        check("abort_pass", pass, 0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("abort_quiet", done_seen, 0);

        // Reset mid-sweep at vec_idx 5 clears everything
        pulse_start(1);
        wait_vidx(3'd5);
        check("pre_rst_err", err_cnt, 2);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_all_zero("midrst");

        // Start re-asserted while busy must not disturb done timing
        run_sweep(0, 1'b0, 1'b1, 0, 1'b1, 3'd0);

        // Simultaneous start and abort in IDLE: abort wins
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        @(posedge clk);
        #1;
        check("sa_busy2", busy, 0);
        run_sweep(0, 1'b1, 1'b0, 0, 1'b1, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
